io_input_debouncer: RTL and testbench

IO_INPUT_DEBOUNCER -- requirements
Module: io_input_debouncer

---
 rtl/io_pkg.sv | 14 +
 rtl/io_input_debouncer_debounce_bit.sv | 104 ++++++++++
 rtl/io_input_debouncer.sv | 56 +++++
 tb/tb_io_input_debouncer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared IO constants and the per-bit debouncer state encoding.
// Memory-mapped read addresses select which nibble of io_data is returned.
package io_pkg;

    localparam int unsigned IO_WIDTH     = 8;
    localparam logic [15:0] IO_ADDR_LOW  = 16'hFFFD;
    localparam logic [15:0] IO_ADDR_HIGH = 16'hFFFE;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/io_input_debouncer_debounce_bit.sv
// One debounced input bit: synchronizer chain, mismatch counter, two-state FSM
// and registered rise/fall strobes. rise_next/fall_next expose the pulse values
// being loaded so the parent can register its OR-reduction on the same edge.
module debounce_bit
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_COUNT = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic stable_out,
    output logic rise_out,
    output logic fall_out,
    output logic rise_next,
    output logic fall_next
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    db_state_e              state_q;
    db_state_e              state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       cnt_inc_s;
    logic                   sync_s;
    logic                   data_q;
    logic                   data_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

    // Stage 0 is the only flop that ever sees raw_in.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    end

    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign cnt_inc_s = cnt_q + CNT_ONE;

    // The count is the length of the current run of mismatching samples;
    // committing on cnt_inc_s == CNT_LAST also covers DEBOUNCE_COUNT = 1 from STABLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_STABLE, ST_PENDING: begin
                if (sync_s == data_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_inc_s == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = CNT_ZERO;
                    data_d  = sync_s;
                    rise_d  = sync_s;
                    fall_d  = ~sync_s;
                end else begin
                    state_d = ST_PENDING;
                    cnt_d   = cnt_inc_s;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, synchronizer and outputs all clear asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            state_q <= ST_STABLE;
            cnt_q   <= CNT_ZERO;
            data_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign stable_out = data_q;
    assign rise_out   = rise_q;
    assign fall_out   = fall_q;
    assign rise_next  = rise_d;
    assign fall_next  = fall_d;

endmodule

// File: rtl/io_input_debouncer.sv
// WIDTH independent debounced inputs feeding the IO read mux, with per-bit
// edge strobes and a registered any-change flag.
module io_input_debouncer
    import io_pkg::*;
#(
    parameter int unsigned WIDTH          = IO_WIDTH,
    parameter int unsigned DEBOUNCE_COUNT = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] io_data,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    logic [WIDTH-1:0] rise_next_s;
    logic [WIDTH-1:0] fall_next_s;
    logic             changed_d;
    logic             changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_bit (
            .clock      (clock),
            .reset      (reset),
            .raw_in     (raw_in[i]),
            .stable_out (io_data[i]),
            .rise_out   (rise_pulse[i]),
            .fall_out   (fall_pulse[i]),
            .rise_next  (rise_next_s[i]),
            .fall_next  (fall_next_s[i])
        );
    end

    // Built from the pulses being loaded so it lines up with them.
    always_comb begin
        changed_d = |(rise_next_s | fall_next_s);
    end

    // Any-change flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_io_input_debouncer.sv
// Directed and randomized bench for io_input_debouncer (DEBOUNCE_COUNT = 4,
// SYNC_STAGES = 2) against a sample-window reference model.
module tb_io_input_debouncer;

    localparam int DC = 4;
    localparam int SS = 2;
    localparam int W  = 8;

    logic         clock;
    logic         reset;
    logic [W-1:0] raw_in;
    logic [W-1:0] io_data;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic         changed;

    int checks = 0;
    int errors = 0;

    // Model: a bit's stable level flips when the DC raw samples taken SS..SS+DC-1
    // edges ago all differ from it. Samples before reset release count as 0.
    logic [W-1:0] hist[$];
    logic [W-1:0] exp_data;
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_fall;
    logic         exp_changed;
    logic [W-1:0] pulse_acc;
    int           rise5_cnt;

    io_input_debouncer #(
        .WIDTH          (W),
        .DEBOUNCE_COUNT (DC),
        .SYNC_STAGES    (SS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .raw_in     (raw_in),
        .io_data    (io_data),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .changed    (changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SS + DC; i++) hist.push_back('0);
        exp_data    = '0;
        exp_rise    = '0;
        exp_fall    = '0;
        exp_changed = 1'b0;
    endtask

    task automatic model_edge();
        int  n;
        logic all_diff;
        exp_rise = '0;
        exp_fall = '0;
        if (reset) begin
            model_reset();
        end else begin
            hist.push_back(raw_in);
            n = hist.size();
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    if (hist[n-1-SS-j][b] == exp_data[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    exp_data[b] = ~exp_data[b];
                    if (exp_data[b]) exp_rise[b] = 1'b1;
                    else             exp_fall[b] = 1'b1;
                end
            end
            exp_changed = |(exp_rise | exp_fall);
            while (hist.size() > 32) void'(hist.pop_front());
        end
    endtask

    task automatic check_model(input string tag);
        chk8({tag, "_io_data"}, io_data, exp_data);
        chk8({tag, "_rise"}, rise_pulse, exp_rise);
        chk8({tag, "_fall"}, fall_pulse, exp_fall);
        chk1({tag, "_changed"}, changed, exp_changed);
        chk8({tag, "_rise_and_fall"}, rise_pulse & fall_pulse, 8'h00);
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_model(tag);
        pulse_acc = pulse_acc | rise_pulse | fall_pulse;
        if (rise_pulse[5]) rise5_cnt++;
    endtask

    initial begin
        reset     = 1'b1;
        raw_in    = 8'hFF;
        pulse_acc = '0;
        rise5_cnt = 0;
        model_reset();

        // All ones held through reset release.
        step("rst");
        step("rst");
        chk8("rst_io_data", io_data, 8'h00);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) step("ff_wait");
        chk8("ff_before_pulse", rise_pulse | io_data, 8'h00);
        chk1("ff_before_changed", changed, 1'b0);
        step("ff_edge6");
        chk8("ff_io_data", io_data, 8'hFF);
        chk8("ff_rise", rise_pulse, 8'hFF);
        chk1("ff_changed", changed, 1'b1);
        step("ff_after");
        chk8("ff_rise_gone", rise_pulse, 8'h00);
        chk1("ff_changed_gone", changed, 1'b0);

        // Return to all zeros, then a 3-cycle glitch on bit 0.
        raw_in = 8'h00;
        for (int i = 0; i < 8; i++) step("to_zero");
        chk8("zero_io_data", io_data, 8'h00);
        pulse_acc = '0;
        raw_in = 8'h01;
        for (int i = 0; i < 3; i++) step("glitch_hi");
        raw_in = 8'h00;
        for (int i = 0; i < 10; i++) step("glitch_lo");
        chk8("glitch_io_data", io_data, 8'h00);
        chk8("glitch_no_pulse", pulse_acc, 8'h00);

        // Bouncing bit 5 settles high: one rise 6 edges after the last rise.
        rise5_cnt = 0;
        raw_in = 8'h20; step("b5"); step("b5");
        raw_in = 8'h00; step("b5"); step("b5");
        raw_in = 8'h20;
        for (int i = 0; i < 5; i++) step("b5_hold");
        chk1("b5_early", io_data[5], 1'b0);
        step("b5_edge6");
        chk1("b5_rise", rise_pulse[5], 1'b1);
        chk1("b5_io_data", io_data[5], 1'b1);
        for (int i = 0; i < 4; i++) step("b5_tail");
        chk1("b5_single_pulse", rise5_cnt == 1, 1'b1);

        // Reset mid-pending on bit 2 discards the partial count.
        raw_in = 8'h24;
        for (int i = 0; i < 3; i++) step("b2_pend");
        reset = 1'b1;
        model_reset();
        #1;
        chk8("b2_async_rst", io_data | rise_pulse | fall_pulse, 8'h00);
        chk1("b2_async_rst_changed", changed, 1'b0);
        step("b2_rst");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step("b2_wait");
        chk1("b2_no_credit", io_data[2], 1'b0);
        step("b2_edge6");
        chk1("b2_io_data", io_data[2], 1'b1);
        chk1("b2_rise", rise_pulse[2], 1'b1);

        // Simultaneous fall on bit 0 and rise on bit 7.
        raw_in = 8'h01;
        for (int i = 0; i < 8; i++) step("to_01");
        chk8("sim_start", io_data, 8'h01);
        raw_in = 8'h80;
        for (int i = 0; i < 5; i++) step("sim_wait");
        step("sim_edge6");
        chk8("sim_fall", fall_pulse, 8'h01);
        chk8("sim_rise", rise_pulse, 8'h80);
        chk1("sim_changed", changed, 1'b1);
        chk8("sim_io_data", io_data, 8'h80);
        step("sim_after");
        chk1("sim_changed_gone", changed, 1'b0);

        // Random bouncing with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 3) == 0) raw_in[b] = ~raw_in[b];
            end
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_model("rnd_async_rst");
            end
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
